// File: rtl/clken_monitor.sv
// Receive-side supervisor for a single-cycle clock-enable pulse train: measures the
// spacing between pulses, flags early/late pulses and declares lock after a good run.
module clken_monitor #(
    parameter int EXP_PERIOD = 17,
    parameter int TOL        = 0,
    parameter int LOCK_CNT   = 4,
    parameter int WIDTH      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clken,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             err_early,
    output logic             err_late,
    output logic [7:0]       err_cnt
);

    // A tolerance wider than the period would underflow the lower bound; clamp to 1.
    localparam int LO = (TOL >= EXP_PERIOD) ? 1 : EXP_PERIOD - TOL;
    localparam int HI = EXP_PERIOD + TOL;
    localparam int GW = $clog2(LOCK_CNT + 1);

    localparam logic [WIDTH-1:0] LO_W    = WIDTH'(LO);
    localparam logic [WIDTH-1:0] HI_W    = WIDTH'(HI);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [GW-1:0]    LOCK_G  = GW'(LOCK_CNT);

    typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] cnt, cnt_n;
    logic [GW-1:0]    good_cnt, good_n;
    logic [WIDTH-1:0] period_n;
    logic             pv_n, early_n, late_n, err_inc;
    logic [7:0]       err_cnt_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            good_cnt     <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            err_early    <= 1'b0;
            err_late     <= 1'b0;
            err_cnt      <= '0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            good_cnt     <= good_n;
            period       <= period_n;
            period_valid <= pv_n;
            locked       <= (state_n == LOCKED);
            err_early    <= early_n;
            err_late     <= late_n;
            err_cnt      <= err_cnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        good_n   = good_cnt;
        period_n = period;
        pv_n     = 1'b0;
        early_n  = 1'b0;
        late_n   = 1'b0;
        err_inc  = 1'b0;
        cnt_n    = clken ? WIDTH'(1) : ((cnt == CNT_MAX) ? cnt : cnt + 1'b1);

        unique case (state)
            IDLE: begin
                if (clken) begin
                    state_n = ACQ;
                    good_n  = '0;
                end
            end
            ACQ, LOCKED: begin
                if (clken) begin
                    period_n = cnt;
                    pv_n     = 1'b1;
                    if (cnt < LO_W) begin
                        // Early pulse becomes the new reference; acquisition restarts.
                        early_n = 1'b1;
                        err_inc = 1'b1;
                        good_n  = '0;
                        state_n = ACQ;
                    end else if (cnt <= HI_W) begin
                        good_n = (good_cnt == LOCK_G) ? good_cnt : good_cnt + 1'b1;
                        if (good_n == LOCK_G)
                            state_n = LOCKED;
                    end
                end else if (cnt == HI_W) begin
                    // Window closed with no pulse: drop the reference entirely.
                    late_n  = 1'b1;
                    err_inc = 1'b1;
                    good_n  = '0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        err_cnt_n = (err_inc && err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt;
    end

endmodule
